// File: rtl/filtro_pkg.sv
// Shared types and width helpers for the time-multiplexed MAC filter stage.
package filtro_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  // Sized so that TAPS full-scale products can be summed without wrapping.
  function automatic int acc_w(input int n, input int taps);
    return 2 * n + $clog2(taps);
  endfunction

  function automatic int idx_w(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/trunc_sat.sv
// Rounds the wide accumulator back to N-bit Q format, then saturates or wraps.
module trunc_sat
  import filtro_pkg::*;
#(
  parameter int N     = 25,
  parameter int FRAC  = 16,
  parameter int ROUND = 1,
  parameter int SAT   = 1,
  parameter int ACC_W = 52
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [N-1:0]     y,
  output logic                    ovf
);

  localparam int SH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [ACC_W:0] HALF =
    (ROUND != 0 && FRAC > 0) ? ((ACC_W + 1)'(1) << SH) : '0;
  localparam logic signed [ACC_W:0] SMAX = {{(ACC_W + 2 - N){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SMIN = {{(ACC_W + 2 - N){1'b1}}, {(N - 1){1'b0}}};

  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] shifted;
  logic                  too_high;
  logic                  too_low;

  // One guard bit keeps the rounding increment from ever wrapping.
  always_comb begin
    rounded  = {acc[ACC_W-1], acc} + HALF;
    shifted  = rounded >>> FRAC;
    too_high = shifted > SMAX;
    too_low  = shifted < SMIN;
    ovf      = too_high || too_low;
    y        = shifted[N-1:0];
    if (SAT != 0 && too_high) y = SMAX[N-1:0];
    if (SAT != 0 && too_low)  y = SMIN[N-1:0];
  end

endmodule

// File: rtl/filtro_mac_secuencial.sv
// FIR stage sharing a single multiplier: one tap per cycle, result held until taken.
module filtro_mac_secuencial
  import filtro_pkg::*;
#(
  parameter int N     = 25,
  parameter int FRAC  = 16,
  parameter int TAPS  = 3,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            x_in,
  input  logic                    coef_we,
  input  logic [idx_w(TAPS)-1:0]  coef_addr,
  input  logic [N-1:0]            coef_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            y_out,
  output logic                    ovf
);

  localparam int ACC_W = acc_w(N, TAPS);
  localparam int IDX_W = idx_w(TAPS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(TAPS - 1);

  state_t                  state;
  state_t                  next_state;
  logic signed [N-1:0]     dline [TAPS];
  logic signed [N-1:0]     coef  [TAPS];
  logic signed [ACC_W-1:0] acc;
  logic [IDX_W-1:0]        k;
  logic signed [2*N-1:0]   prod;
  logic [N-1:0]            y_rnd;
  logic                    ovf_rnd;

  assign in_ready = (state == IDLE);
  assign prod     = coef[k] * dline[k];

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = MAC;
      MAC:     if (k == LAST) next_state = OUT;
      OUT:     if (out_valid && out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // OUT spends its first cycle registering the rounded result, then waits for the handshake.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) begin
        dline[i] <= '0;
        coef[i]  <= '0;
      end
      acc       <= '0;
      k         <= '0;
      out_valid <= 1'b0;
      y_out     <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (coef_we && (32'(coef_addr) < TAPS)) coef[coef_addr] <= coef_data;
          if (in_valid) begin
            dline[0] <= x_in;
            for (int i = 1; i < TAPS; i++) dline[i] <= dline[i-1];
            acc <= '0;
            k   <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          k   <= (k == LAST) ? '0 : k + 1'b1;
        end
        OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            y_out     <= y_rnd;
            ovf       <= ovf_rnd;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  trunc_sat #(
    .N     (N),
    .FRAC  (FRAC),
    .ROUND (ROUND),
    .SAT   (SAT),
    .ACC_W (ACC_W)
  ) u_trunc (
    .acc (acc),
    .y   (y_rnd),
    .ovf (ovf_rnd)
  );

endmodule
